// File: rtl/rtc_pkg.sv
// Shared types for the RTC access scheduler: FSM states, operation codes and BCD field widths.
package rtc_pkg;

    localparam int TIME_W = 24;
    localparam int DATE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_TIME = 2'd0,
        OP_DATE = 2'd1,
        OP_READ = 2'd2
    } op_e;

endpackage

// File: rtl/rtc_tick_cnt.sv
// Up-counter 0..TC-1 with enable and synchronous clear; o_wrap flags the terminal count while enabled.
module rtc_tick_cnt #(
    parameter int TC = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int W = (TC > 1) ? $clog2(TC) : 1;
    localparam logic [W-1:0] LAST = W'(TC - 1);

    logic [W-1:0] r_cnt;

    assign o_wrap = i_en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr || o_wrap) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/rtc_access_sched.sv
// Schedules set-time, set-date and periodic read transactions toward an RTC controller with timeout/retry.
// Optional alarm compare on captured time is enabled by defining RTC_ALARM_EN.
//
//  state    | meaning
//  ST_IDLE  | nothing in flight; picks pending op (time > date > read)
//  ST_ISSUE | one cycle, command pulse asserted
//  ST_WAIT  | waiting for matching done, timeout timer running
module rtc_access_sched
    import rtc_pkg::*;
#(
    parameter int POLL_CYC    = 15_000_000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_time,
    input  logic [TIME_W-1:0] req_time_dat,
    input  logic              req_date,
    input  logic [DATE_W-1:0] req_date_dat,
    output logic              set_time,
    output logic [TIME_W-1:0] time_2_set,
    output logic              set_date,
    output logic [DATE_W-1:0] date_2_set,
    output logic              read,
    input  logic              set_done,
    input  logic              read_done,
    input  logic [TIME_W-1:0] time_in,
    input  logic [DATE_W-1:0] date_in,
    output logic [TIME_W-1:0] time_out,
    output logic [DATE_W-1:0] date_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_set,
    input  logic [TIME_W-1:0] alarm_dat,
    output logic              alarm_hit
`endif
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_e r_state, w_state_nx;
    op_e    r_op, w_op_nx;
    logic [RW-1:0] r_retry, w_retry_nx;

    logic              r_pend_time, r_pend_date, r_pend_rd;
    logic [TIME_W-1:0] r_time_dat;
    logic [DATE_W-1:0] r_date_dat;
    logic [TIME_W-1:0] r_time_2_set, r_time_out;
    logic [DATE_W-1:0] r_date_2_set, r_date_out;
    logic              r_rd_valid, r_err;

    logic              w_poll_wrap, w_tmo, w_in_wait, w_done_ok;
    logic              w_pend_time, w_pend_date, w_pend_rd;
    logic [TIME_W-1:0] w_time_dat;
    logic [DATE_W-1:0] w_date_dat;
    logic              w_take_time, w_take_date, w_take_rd, w_capture, w_err_set;

    assign w_in_wait = (r_state == ST_WAIT);

    rtc_tick_cnt #(.TC(POLL_CYC)) u_poll (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (1'b1),
        .i_clr  (1'b0),
        .o_wrap (w_poll_wrap)
    );

    rtc_tick_cnt #(.TC(TIMEOUT_CYC)) u_wait (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (w_in_wait),
        .i_clr  (!w_in_wait),
        .o_wrap (w_tmo)
    );

    // Requests arriving this cycle are merged so an idle FSM can take them immediately.
    assign w_pend_time = r_pend_time | req_time;
    assign w_pend_date = r_pend_date | req_date;
    assign w_pend_rd   = r_pend_rd | w_poll_wrap;
    assign w_time_dat  = req_time ? req_time_dat : r_time_dat;
    assign w_date_dat  = req_date ? req_date_dat : r_date_dat;
    assign w_done_ok   = (r_op == OP_READ) ? read_done : set_done;

    always_comb begin
        w_state_nx  = r_state;
        w_op_nx     = r_op;
        w_retry_nx  = r_retry;
        w_take_time = 1'b0;
        w_take_date = 1'b0;
        w_take_rd   = 1'b0;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pend_time) begin
                    w_take_time = 1'b1;
                    w_op_nx     = OP_TIME;
                end else if (w_pend_date) begin
                    w_take_date = 1'b1;
                    w_op_nx     = OP_DATE;
                end else if (w_pend_rd) begin
                    w_take_rd   = 1'b1;
                    w_op_nx     = OP_READ;
                end
                if (w_pend_time || w_pend_date || w_pend_rd) begin
                    w_state_nx = ST_ISSUE;
                    w_retry_nx = '0;
                end
            end
            ST_ISSUE: w_state_nx = ST_WAIT;
            ST_WAIT: begin
                // A done in the timeout cycle wins over the timeout.
                if (w_done_ok) begin
                    w_state_nx = ST_IDLE;
                    w_capture  = (r_op == OP_READ);
                end else if (w_tmo) begin
                    if (r_retry < RETRY_LIM) begin
                        w_state_nx = ST_ISSUE;
                        w_retry_nx = r_retry + RW'(1);
                    end else begin
                        w_err_set  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_op    <= OP_TIME;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_retry <= w_retry_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_time  <= 1'b0;
            r_pend_date  <= 1'b0;
            r_pend_rd    <= 1'b0;
            r_time_dat   <= '0;
            r_date_dat   <= '0;
            r_time_2_set <= '0;
            r_date_2_set <= '0;
            r_time_out   <= '0;
            r_date_out   <= '0;
            r_rd_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pend_time <= w_pend_time & ~w_take_time;
            r_pend_date <= w_pend_date & ~w_take_date;
            r_pend_rd   <= w_pend_rd & ~w_take_rd;
            if (req_time)    r_time_dat   <= req_time_dat;
            if (req_date)    r_date_dat   <= req_date_dat;
            if (w_take_time) r_time_2_set <= w_time_dat;
            if (w_take_date) r_date_2_set <= w_date_dat;
            if (w_capture) begin
                r_time_out <= time_in;
                r_date_out <= date_in;
            end
            r_rd_valid <= w_capture;
            if (w_err_set)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign set_time   = (r_state == ST_ISSUE) && (r_op == OP_TIME);
    assign set_date   = (r_state == ST_ISSUE) && (r_op == OP_DATE);
    assign read       = (r_state == ST_ISSUE) && (r_op == OP_READ);
    assign busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign time_2_set = r_time_2_set;
    assign date_2_set = r_date_2_set;
    assign time_out   = r_time_out;
    assign date_out   = r_date_out;
    assign rd_valid   = r_rd_valid;
    assign err        = r_err;

`ifdef RTC_ALARM_EN
    logic [TIME_W-1:0] r_alarm;
    logic              r_alarm_hit;

    // Hit only on the capture that first brings time_out onto the alarm value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_alarm     <= '0;
            r_alarm_hit <= 1'b0;
        end else begin
            if (alarm_set) r_alarm <= alarm_dat;
            r_alarm_hit <= w_capture && (time_in == r_alarm) && (time_in != r_time_out);
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

endmodule

// File: tb/tb_rtc_access_sched.sv
// Self-checking bench for rtc_access_sched: transaction-level timestamp model, directed scenarios and random traffic.
module tb_rtc_access_sched;

    localparam int P  = 100;
    localparam int TO = 50;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_time, req_date, set_done, read_done, err_clr;
    logic [23:0] req_time_dat, time_in;
    logic [31:0] req_date_dat, date_in;
    logic        set_time, set_date, read, rd_valid, busy, err;
    logic [23:0] time_2_set, time_out;
    logic [31:0] date_2_set, date_out;
`ifdef RTC_ALARM_EN
    logic        alarm_set, alarm_hit;
    logic [23:0] alarm_dat;
`endif

    always #5 clk = ~clk;

    rtc_access_sched #(.POLL_CYC(P), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rstn(rstn),
        .req_time(req_time), .req_time_dat(req_time_dat),
        .req_date(req_date), .req_date_dat(req_date_dat),
        .set_time(set_time), .time_2_set(time_2_set),
        .set_date(set_date), .date_2_set(date_2_set),
        .read(read), .set_done(set_done), .read_done(read_done),
        .time_in(time_in), .date_in(date_in),
        .time_out(time_out), .date_out(date_out),
        .rd_valid(rd_valid), .busy(busy), .err(err), .err_clr(err_clr)
`ifdef RTC_ALARM_EN
        , .alarm_set(alarm_set), .alarm_dat(alarm_dat), .alarm_hit(alarm_hit)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    int c = 0;   // cycle index since reset release

    // Model: a transaction is "active" from its selection until its last WAIT cycle;
    // its command appears at cycle m_issue, done is accepted in m_issue+1 .. m_issue+TO.
    bit          m_active, m_pt, m_pd, m_pr, m_rdv, m_err;
    int          m_op, m_issue, m_attempt;
    logic [23:0] m_tdat, m_t2s, m_tout;
    logic [31:0] m_ddat, m_d2s, m_dout;
`ifdef RTC_ALARM_EN
    logic [23:0] m_alarm;
    bit          m_hit;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pt = 0; m_pd = 0; m_pr = 0; m_rdv = 0; m_err = 0;
        m_op = 0; m_issue = 0; m_attempt = 0;
        m_tdat = '0; m_t2s = '0; m_tout = '0; m_ddat = '0; m_d2s = '0; m_dout = '0;
`ifdef RTC_ALARM_EN
        m_alarm = '0; m_hit = 0;
`endif
    endtask

    task automatic model_step();
        bit done_ok, err_set, n_rdv;
        err_set = 0;
        n_rdv   = 0;
`ifdef RTC_ALARM_EN
        m_hit = 0;
`endif
        if ((c % P) == P - 1) m_pr = 1;
        if (req_time) begin m_pt = 1; m_tdat = req_time_dat; end
        if (req_date) begin m_pd = 1; m_ddat = req_date_dat; end
        if (m_active) begin
            if (c > m_issue) begin
                done_ok = (m_op == 2) ? read_done : set_done;
                if (done_ok) begin
                    if (m_op == 2) begin
`ifdef RTC_ALARM_EN
                        m_hit = (time_in == m_alarm) && (time_in != m_tout);
`endif
                        m_tout = time_in;
                        m_dout = date_in;
                        n_rdv  = 1;
                    end
                    m_active = 0;
                end else if (c == m_issue + TO) begin
                    if (m_attempt < MR) begin
                        m_attempt++;
                        m_issue = c + 1;
                    end else begin
                        err_set  = 1;
                        m_active = 0;
                    end
                end
            end
        end else if (m_pt || m_pd || m_pr) begin
            if (m_pt)      begin m_op = 0; m_pt = 0; m_t2s = m_tdat; end
            else if (m_pd) begin m_op = 1; m_pd = 0; m_d2s = m_ddat; end
            else           begin m_op = 2; m_pr = 0; end
            m_active  = 1;
            m_issue   = c + 1;
            m_attempt = 0;
        end
`ifdef RTC_ALARM_EN
        if (alarm_set) m_alarm = alarm_dat;
`endif
        m_err = err_set ? 1'b1 : (err_clr ? 1'b0 : m_err);
        m_rdv = n_rdv;
    endtask

    task automatic compare_all();
        bit cmd;
        cmd = m_active && (c == m_issue);
        chk("set_time",   32'(set_time),   32'(cmd && m_op == 0));
        chk("set_date",   32'(set_date),   32'(cmd && m_op == 1));
        chk("read",       32'(read),       32'(cmd && m_op == 2));
        chk("busy",       32'(busy),       32'(m_active));
        chk("time_2_set", 32'(time_2_set), 32'(m_t2s));
        chk("date_2_set", date_2_set,      m_d2s);
        chk("time_out",   32'(time_out),   32'(m_tout));
        chk("date_out",   date_out,        m_dout);
        chk("rd_valid",   32'(rd_valid),   32'(m_rdv));
        chk("err",        32'(err),        32'(m_err));
`ifdef RTC_ALARM_EN
        chk("alarm_hit",  32'(alarm_hit),  32'(m_hit));
`endif
    endtask

    task automatic clear_pulses();
        req_time = 0; req_date = 0; set_done = 0; read_done = 0; err_clr = 0;
`ifdef RTC_ALARM_EN
        alarm_set = 0;
`endif
    endtask

    task automatic cycle_end();
        model_step();
        @(posedge clk);
        #1;
        c++;
        compare_all();
        clear_pulses();
    endtask

    task automatic run_to(input int n);
        while (c < n) cycle_end();
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1;
        model_reset();
        c = 0;
        compare_all();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", c);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rate;
        bit in_wait;
        rstn = 0;
        clear_pulses();
        req_time_dat = '0; req_date_dat = '0; time_in = '0; date_in = '0;
`ifdef RTC_ALARM_EN
        alarm_dat = '0;
`endif
        model_reset();
        release_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err",  32'(err),  32'd0);

        // First periodic read exactly POLL_CYC cycles after release.
        run_to(99);
        chk("read_before_poll", 32'(read), 32'd0);
        run_to(100);
        chk("first_read_c100", 32'(read), 32'd1);
        cycle_end();
        read_done = 1; time_in = 24'h123456; date_in = 32'h20240101;
        cycle_end();
        chk("capture_time", 32'(time_out), 32'h123456);
        chk("rd_valid_pulse", 32'(rd_valid), 32'd1);
        cycle_end();
        chk("rd_valid_one_cycle", 32'(rd_valid), 32'd0);

        // Simultaneous time/date requests: time first, date only after set_done.
        run_to(110);
        req_time = 1; req_time_dat = 24'h235959;
        req_date = 1; req_date_dat = 32'h20240115;
        cycle_end();
        chk("set_time_first", 32'(set_time), 32'd1);
        chk("time_2_set_val", 32'(time_2_set), 32'h235959);
        chk("no_set_date_yet", 32'(set_date), 32'd0);
        run_to(115);
        set_done = 1;
        cycle_end();
        run_to(117);
        chk("set_date_after_done", 32'(set_date), 32'd1);
        chk("date_2_set_val", date_2_set, 32'h20240115);
        run_to(120);
        set_done = 1;
        cycle_end();

        // Two time requests during a busy read merge; then exhaust retries.
        run_to(200);
        chk("second_read_c200", 32'(read), 32'd1);
        run_to(205);
        req_time = 1; req_time_dat = 24'h010203;
        cycle_end();
        run_to(210);
        req_time = 1; req_time_dat = 24'h040506;
        cycle_end();
        run_to(220);
        read_done = 1; time_in = 24'h000001;
        cycle_end();
        run_to(222);
        chk("merged_set_time", 32'(set_time), 32'd1);
        chk("latest_data_wins", 32'(time_2_set), 32'h040506);
        run_to(273);
        chk("retry1_set_time", 32'(set_time), 32'd1);
        run_to(324);
        chk("retry2_set_time", 32'(set_time), 32'd1);
        run_to(374);
        chk("err_not_yet", 32'(err), 32'd0);
        run_to(375);
        chk("err_after_retries", 32'(err), 32'd1);
        run_to(380);
        err_clr = 1; read_done = 1; time_in = 24'h000002;
        cycle_end();
        chk("err_cleared", 32'(err), 32'd0);

        // Random traffic with varying completion rates (some produce timeouts/errors).
        for (int blk = 0; blk < 4; blk++) begin
            case (blk % 3)
                0: rate = 8;
                1: rate = 40;
                default: rate = 200;
            endcase
            for (int k = 0; k < 2000; k++) begin
                req_time     = ($urandom_range(0, 149) == 0);
                req_time_dat = 24'($urandom);
                req_date     = ($urandom_range(0, 149) == 0);
                req_date_dat = $urandom;
                set_done     = ($urandom_range(0, rate - 1) == 0);
                read_done    = ($urandom_range(0, rate - 1) == 0);
                time_in      = 24'($urandom);
                date_in      = $urandom;
                err_clr      = ($urandom_range(0, 199) == 0);
`ifdef RTC_ALARM_EN
                alarm_set    = ($urandom_range(0, 299) == 0);
                alarm_dat    = 24'($urandom_range(0, 3));
                time_in      = 24'($urandom_range(0, 3));
`endif
                cycle_end();
            end
        end

        // Reset in the middle of a WAIT.
        in_wait = m_active && (c > m_issue);
        for (int k = 0; k < 500 && !in_wait; k++) begin
            cycle_end();
            in_wait = m_active && (c > m_issue);
        end
        chk("reached_wait", 32'(in_wait), 32'd1);
        rstn = 0;
        #1;
        chk("rst_set_time",   32'(set_time),   32'd0);
        chk("rst_set_date",   32'(set_date),   32'd0);
        chk("rst_read",       32'(read),       32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_err",        32'(err),        32'd0);
        chk("rst_rd_valid",   32'(rd_valid),   32'd0);
        chk("rst_time_2_set", 32'(time_2_set), 32'd0);
        chk("rst_date_2_set", date_2_set,      32'd0);
        chk("rst_time_out",   32'(time_out),   32'd0);
        chk("rst_date_out",   date_out,        32'd0);
        release_reset();
        run_to(99);
        chk("post_rst_no_read", 32'(read), 32'd0);
        run_to(100);
        chk("post_rst_read_c100", 32'(read), 32'd1);
        cycle_end();
        read_done = 1;
        cycle_end();
        cycle_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
